block_bounce_ctrl: RTL and testbench

Game-logic stage between the key debouncers and `vga_ctrl`. Keeps a rectangular block moving on the 800x600 active area, bounces it off all four edges, and changes its speed or pauses it on debounced key pulses. It also renders the block: for each pixel coordinate from `vga_ctrl`, it returns the block or background colour on `vga_data`. Position changes only at the start of vertical blanking, so a frame is never torn.

---
 rtl/vga_game_pkg.sv | 69 ++++++
 rtl/block_pixel_render.sv | 57 +++++
 rtl/block_bounce_ctrl.sv | 145 ++++++++++++++
 tb/tb_block_bounce_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_game_pkg.sv
// Shared constants, state/direction types and the per-axis bounce step used by
// the block game logic.
package vga_game_pkg;

    localparam int unsigned H_ACTIVE       = 800;
    localparam int unsigned V_ACTIVE       = 600;
    localparam logic [7:0]  DEF_BLK_COLOUR = 8'hFF;
    localparam logic [7:0]  DEF_BG_COLOUR  = 8'h00;
    localparam int unsigned SPD_W          = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_e;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_e;

    typedef struct packed {
        logic [9:0] pos;
        dir_e       dir;
    } axis_t;

    // One bounce step on a single axis; limit is the largest legal position.
    function automatic axis_t axis_move(
        input logic [9:0]       pos,
        input dir_e             dir,
        input logic [SPD_W-1:0] speed,
        input logic [10:0]      limit
    );
        axis_t       res;
        logic [10:0] pos_w;
        logic [10:0] spd_w;
        logic [10:0] sum_w;
        pos_w   = {1'b0, pos};
        spd_w   = {{(11-SPD_W){1'b0}}, speed};
        sum_w   = pos_w + spd_w;
        res.pos = pos;
        res.dir = dir;
        case (dir)
            DIR_INC: begin
                if (sum_w >= limit) begin
                    res.pos = limit[9:0];
                    res.dir = DIR_DEC;
                end else begin
                    res.pos = sum_w[9:0];
                    res.dir = DIR_INC;
                end
            end
            DIR_DEC: begin
                if (pos_w <= spd_w) begin
                    res.pos = 10'd0;
                    res.dir = DIR_INC;
                end else begin
                    res.pos = pos - spd_w[9:0];
                    res.dir = DIR_DEC;
                end
            end
            default: begin
                res.pos = pos;
                res.dir = DIR_INC;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/block_pixel_render.sv
// Registered pixel colour: block colour inside the block rectangle, background
// elsewhere in the active area, black during blanking.
module block_pixel_render #(
    parameter int unsigned H_ACTIVE   = vga_game_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE   = vga_game_pkg::V_ACTIVE,
    parameter int unsigned BLK_W      = 40,
    parameter int unsigned BLK_H      = 40,
    parameter logic [7:0]  BLK_COLOUR = vga_game_pkg::DEF_BLK_COLOUR,
    parameter logic [7:0]  BG_COLOUR  = vga_game_pkg::DEF_BG_COLOUR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] blk_x_i,
    input  logic [9:0] blk_y_i,
    input  logic [9:0] pix_x_i,
    input  logic [9:0] pix_y_i,
    output logic [7:0] vga_data_o
);

    logic       x_in_s;
    logic       y_in_s;
    logic       active_s;
    logic [7:0] colour_d;
    logic [7:0] colour_q;

    // Compare at 11 bits so blk + size cannot wrap.
    assign x_in_s   = ({1'b0, pix_x_i} >= {1'b0, blk_x_i}) &&
                      ({1'b0, pix_x_i} <  ({1'b0, blk_x_i} + 11'(BLK_W)));
    assign y_in_s   = ({1'b0, pix_y_i} >= {1'b0, blk_y_i}) &&
                      ({1'b0, pix_y_i} <  ({1'b0, blk_y_i} + 11'(BLK_H)));
    assign active_s = ({1'b0, pix_x_i} < 11'(H_ACTIVE)) &&
                      ({1'b0, pix_y_i} < 11'(V_ACTIVE));

    // Colour select for the current pixel.
    always_comb begin
        colour_d = 8'h00;
        if (x_in_s && y_in_s) begin
            colour_d = BLK_COLOUR;
        end else if (active_s) begin
            colour_d = BG_COLOUR;
        end else begin
            colour_d = 8'h00;
        end
    end

    // Output register giving the one-pixel latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            colour_q <= 8'h00;
        end else begin
            colour_q <= colour_d;
        end
    end

    assign vga_data_o = colour_q;

endmodule

// File: rtl/block_bounce_ctrl.sv
// Bouncing-block game logic: frame tick detection, run/pause FSM, speed
// selection, per-frame position update and pixel rendering.
module block_bounce_ctrl #(
    parameter int unsigned H_ACTIVE   = vga_game_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE   = vga_game_pkg::V_ACTIVE,
    parameter int unsigned BLK_W      = 40,
    parameter int unsigned BLK_H      = 40,
    parameter int unsigned X0         = 380,
    parameter int unsigned Y0         = 280,
    parameter int unsigned MAX_SPEED  = 7,
    parameter logic [7:0]  BLK_COLOUR = vga_game_pkg::DEF_BLK_COLOUR,
    parameter logic [7:0]  BG_COLOUR  = vga_game_pkg::DEF_BG_COLOUR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_flag1,
    input  logic       key_flag2,
    input  logic [9:0] vga_xide,
    input  logic [9:0] vga_yide,
    output logic [7:0] vga_data,
    output logic [9:0] blk_x,
    output logic [9:0] blk_y,
    output logic       paused
);

    import vga_game_pkg::*;

    localparam logic [10:0]      X_LIMIT     = 11'(H_ACTIVE - BLK_W);
    localparam logic [10:0]      Y_LIMIT     = 11'(V_ACTIVE - BLK_H);
    localparam logic [9:0]       Y_LAST_ROW  = 10'(V_ACTIVE - 1);
    localparam logic [9:0]       Y_BLANK_ROW = 10'(V_ACTIVE);
    localparam logic [SPD_W-1:0] SPD_MAX     = SPD_W'(MAX_SPEED);
    localparam logic [SPD_W-1:0] SPD_ONE     = SPD_W'(1);

    logic [9:0]       y_prev_q;
    logic             tick_s;
    state_e           state_q;
    state_e           state_d;
    logic [SPD_W-1:0] speed_q;
    logic [SPD_W-1:0] speed_d;
    logic [9:0]       blk_x_q;
    logic [9:0]       blk_x_d;
    logic [9:0]       blk_y_q;
    logic [9:0]       blk_y_d;
    dir_e             dir_x_q;
    dir_e             dir_x_d;
    dir_e             dir_y_q;
    dir_e             dir_y_d;
    axis_t            move_x_s;
    axis_t            move_y_s;

    // One tick per frame: last active line to first blanking line.
    assign tick_s = (y_prev_q == Y_LAST_ROW) && (vga_yide == Y_BLANK_ROW);

    // Run/pause next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (key_flag2) state_d = ST_PAUSE;
                else           state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (key_flag2) state_d = ST_RUN;
                else           state_d = ST_PAUSE;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Speed steps 1..MAX_SPEED and wraps back to 1.
    always_comb begin
        speed_d = speed_q;
        if (key_flag1) begin
            if (speed_q >= SPD_MAX) speed_d = SPD_ONE;
            else                    speed_d = speed_q + SPD_ONE;
        end else begin
            speed_d = speed_q;
        end
    end

    // Position update: the move uses the speed in effect before any key this cycle.
    always_comb begin
        move_x_s = axis_move(blk_x_q, dir_x_q, speed_q, X_LIMIT);
        move_y_s = axis_move(blk_y_q, dir_y_q, speed_q, Y_LIMIT);
        blk_x_d  = blk_x_q;
        blk_y_d  = blk_y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        if (tick_s && (state_q == ST_RUN)) begin
            blk_x_d = move_x_s.pos;
            dir_x_d = move_x_s.dir;
            blk_y_d = move_y_s.pos;
            dir_y_d = move_y_s.dir;
        end else begin
            blk_x_d = blk_x_q;
            blk_y_d = blk_y_q;
            dir_x_d = dir_x_q;
            dir_y_d = dir_y_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_prev_q <= 10'd0;
            state_q  <= ST_RUN;
            speed_q  <= SPD_ONE;
            blk_x_q  <= 10'(X0);
            blk_y_q  <= 10'(Y0);
            dir_x_q  <= DIR_INC;
            dir_y_q  <= DIR_INC;
        end else begin
            y_prev_q <= vga_yide;
            state_q  <= state_d;
            speed_q  <= speed_d;
            blk_x_q  <= blk_x_d;
            blk_y_q  <= blk_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
        end
    end

    assign blk_x  = blk_x_q;
    assign blk_y  = blk_y_q;
    assign paused = (state_q == ST_PAUSE);

    block_pixel_render #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .BLK_W      (BLK_W),
        .BLK_H      (BLK_H),
        .BLK_COLOUR (BLK_COLOUR),
        .BG_COLOUR  (BG_COLOUR)
    ) u_render (
        .clk        (clk),
        .rst        (rst),
        .blk_x_i    (blk_x_q),
        .blk_y_i    (blk_y_q),
        .pix_x_i    (vga_xide),
        .pix_y_i    (vga_yide),
        .vga_data_o (vga_data)
    );

endmodule

// File: tb/tb_block_bounce_ctrl.sv
// Bench for block_bounce_ctrl: table vectors, hand-written wall/speed/pause
// sequences and random stimulus against a behavioural model.
module tb_block_bounce_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_flag1;
    logic       key_flag2;
    logic [9:0] vga_xide;
    logic [9:0] vga_yide;
    logic [7:0] vga_data;
    logic [9:0] blk_x;
    logic [9:0] blk_y;
    logic       paused;

    block_bounce_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .key_flag1 (key_flag1),
        .key_flag2 (key_flag2),
        .vga_xide  (vga_xide),
        .vga_yide  (vga_yide),
        .vga_data  (vga_data),
        .blk_x     (blk_x),
        .blk_y     (blk_y),
        .paused    (paused)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: position, direction as +1/-1, speed, pause flag.
    int m_x, m_y, m_dx, m_dy, m_spd, m_yprev, m_data;
    bit m_paused;

    typedef struct {
        bit r, k1, k2;
        int px, py;
        int ex, ey, ep, ed;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 380; m_y = 280; m_dx = 1; m_dy = 1;
        m_spd = 1; m_paused = 1'b0; m_yprev = 0; m_data = 0;
    endtask

    task automatic model_axis(inout int p, inout int d, input int lim);
        int nx;
        nx = p + d * m_spd;
        if (d > 0 && nx >= lim) begin
            p = lim; d = -1;
        end else if (d < 0 && nx <= 0) begin
            p = 0; d = 1;
        end else begin
            p = nx;
        end
    endtask

    // Drive one cycle, advance the model across the edge, compare all outputs.
    task automatic apply(input bit r, input bit k1, input bit k2, input int px, input int py);
        bit tick;
        rst = r; key_flag1 = k1; key_flag2 = k2;
        vga_xide = px[9:0]; vga_yide = py[9:0];
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            tick = (m_yprev == 599) && (py == 600);
            m_data = (px >= m_x && px < m_x + 40 && py >= m_y && py < m_y + 40) ? 255 : 0;
            if (tick && !m_paused) begin
                model_axis(m_x, m_dx, 760);
                model_axis(m_y, m_dy, 560);
            end
            if (k1) m_spd = (m_spd == 7) ? 1 : m_spd + 1;
            if (k2) m_paused = !m_paused;
            m_yprev = py;
        end
        #1;
        chk("blk_x", 32'(blk_x), 32'(m_x));
        chk("blk_y", 32'(blk_y), 32'(m_y));
        chk("paused", 32'(paused), 32'(m_paused));
        chk("vga_data", 32'(vga_data), 32'(m_data));
    endtask

    task automatic tick_once(input bit k1, input bit k2);
        apply(1'b0, 1'b0, 1'b0, 0, 599);
        apply(1'b0, k1, k2, 0, 600);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_once(1'b0, 1'b0);
    endtask

    function automatic int clamp10(input int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    initial begin
        int last_py;
        int sel;
        int px, py;
        model_reset();

        tbl[0] = '{1, 0, 0,   0,   0, 380, 280, 0,   0};
        tbl[1] = '{0, 0, 0, 380, 280, 380, 280, 0, 255};
        tbl[2] = '{0, 0, 0, 420, 280, 380, 280, 0,   0};
        tbl[3] = '{0, 0, 0, 850, 100, 380, 280, 0,   0};
        tbl[4] = '{0, 0, 0, 419, 319, 380, 280, 0, 255};
        tbl[5] = '{0, 0, 0, 379, 280, 380, 280, 0,   0};
        tbl[6] = '{0, 0, 0, 380, 320, 380, 280, 0,   0};
        tbl[7] = '{0, 0, 0,   0, 599, 380, 280, 0,   0};
        tbl[8] = '{0, 0, 0,   0, 600, 381, 281, 0,   0};
        tbl[9] = '{0, 0, 0, 381, 281, 381, 281, 0, 255};

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].r, tbl[i].k1, tbl[i].k2, tbl[i].px, tbl[i].py);
            chk("tbl_x", 32'(blk_x), 32'(tbl[i].ex));
            chk("tbl_y", 32'(blk_y), 32'(tbl[i].ey));
            chk("tbl_paused", 32'(paused), 32'(tbl[i].ep));
            chk("tbl_data", 32'(vga_data), 32'(tbl[i].ed));
        end

        // Speed wrap and tick/key collision.
        apply(1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 6; i++) apply(1'b0, 1'b1, 1'b0, 100, 100);
        tick_once(1'b0, 1'b0);
        chk("spd7_x", 32'(blk_x), 32'd387);
        chk("spd7_y", 32'(blk_y), 32'd287);
        apply(1'b0, 1'b1, 1'b0, 100, 100);
        tick_once(1'b0, 1'b0);
        chk("wrap_x", 32'(blk_x), 32'd388);
        tick_once(1'b1, 1'b0);
        chk("k1_tick_x", 32'(blk_x), 32'd389);
        tick_once(1'b0, 1'b0);
        chk("spd2_x", 32'(blk_x), 32'd391);

        // Pause behaviour.
        apply(1'b0, 1'b0, 1'b1, 100, 100);
        ticks(3);
        chk("pause_x", 32'(blk_x), 32'd391);
        chk("pause_y", 32'(blk_y), 32'd391 - 32'd100);
        chk("pause_flag", 32'(paused), 32'd1);
        tick_once(1'b0, 1'b1);
        chk("unpause_tick_x", 32'(blk_x), 32'd391);
        chk("unpause_flag", 32'(paused), 32'd0);
        tick_once(1'b0, 1'b1);
        chk("run_tick_pause_x", 32'(blk_x), 32'd393);
        chk("run_tick_pause_flag", 32'(paused), 32'd1);
        apply(1'b1, 1'b0, 1'b0, 100, 100);
        chk("rst_pause_x", 32'(blk_x), 32'd380);
        chk("rst_pause_y", 32'(blk_y), 32'd280);
        chk("rst_pause_flag", 32'(paused), 32'd0);
        apply(1'b0, 1'b0, 1'b1, 100, 100);
        apply(1'b0, 1'b0, 1'b1, 100, 100);
        tick_once(1'b0, 1'b0);
        chk("resume_x", 32'(blk_x), 32'd381);
        apply(1'b0, 1'b1, 1'b1, 100, 100);
        chk("both_keys_flag", 32'(paused), 32'd1);
        apply(1'b0, 1'b0, 1'b1, 100, 100);
        tick_once(1'b0, 1'b0);
        chk("both_keys_x", 32'(blk_x), 32'd383);

        // Right and left walls.
        apply(1'b1, 1'b0, 1'b0, 0, 0);
        ticks(379);
        chk("pre_right_x", 32'(blk_x), 32'd759);
        chk("pre_right_y", 32'(blk_y), 32'd461);
        tick_once(1'b0, 1'b0);
        chk("right_wall_x", 32'(blk_x), 32'd760);
        tick_once(1'b0, 1'b0);
        chk("right_back_x", 32'(blk_x), 32'd759);
        ticks(757);
        chk("pre_left_x", 32'(blk_x), 32'd2);
        apply(1'b0, 1'b1, 1'b0, 100, 100);
        apply(1'b0, 1'b1, 1'b0, 100, 100);
        tick_once(1'b0, 1'b0);
        chk("left_wall_x", 32'(blk_x), 32'd0);
        tick_once(1'b0, 1'b0);
        chk("left_back_x", 32'(blk_x), 32'd3);

        // Random stimulus against the model.
        last_py = 0;
        for (int i = 0; i < 4000; i++) begin
            sel = int'($urandom_range(0, 4));
            if (last_py == 599 && $urandom_range(0, 1) == 1) py = 600;
            else if (sel <= 1) py = 599;
            else if (sel == 2) py = clamp10(m_y + int'($urandom_range(0, 41)) - 1);
            else py = int'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1) px = clamp10(m_x + int'($urandom_range(0, 41)) - 1);
            else px = int'($urandom_range(0, 1023));
            apply($urandom_range(0, 499) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 31) == 0, px, py);
            last_py = py;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
